// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the memory stage and the data LSU.
// Valid/ready on both the request and the response channel.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 12
);
  logic              io_req_valid;
  logic              io_req_ready;
  logic [ADDR_W-1:0] io_req_addr;
  logic [1:0]        io_req_func;
  logic [2:0]        io_req_typ;
  logic [31:0]       io_req_wdata;
  logic              io_resp_valid;
  logic              io_resp_ready;
  logic [31:0]       io_resp_rdata;
  logic              io_resp_err;

  modport master (
    output io_req_valid,
    input  io_req_ready,
    output io_req_addr,
    output io_req_func,
    output io_req_typ,
    output io_req_wdata,
    input  io_resp_valid,
    output io_resp_ready,
    input  io_resp_rdata,
    input  io_resp_err
  );

  modport slave (
    input  io_req_valid,
    output io_req_ready,
    input  io_req_addr,
    input  io_req_func,
    input  io_req_typ,
    input  io_req_wdata,
    output io_resp_valid,
    input  io_resp_ready,
    output io_resp_rdata,
    output io_resp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Word-organised data RAM with B/H/W access, load extension, registered resp.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned H/W instead of aligning.
module data_mem_lsu #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           reset_n,
  data_mem_lsu_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic        r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_rd;
  logic              w_wr;
  logic              w_we;
  logic              w_b;
  logic              w_h;
  logic              w_w;
  logic              w_sgn;
  logic              w_bad;
  logic              w_mis;
  logic              w_err;
  logic [1:0]        w_off;
  logic [ADDR_W-3:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdat;
  logic [31:0]       w_word;
  logic [31:0]       w_shift;
  logic [31:0]       w_ext;

  always_comb begin
    w_b   = 1'b0;
    w_h   = 1'b0;
    w_w   = 1'b0;
    w_sgn = 1'b0;
    w_bad = 1'b0;
    case (bus.io_req_typ)
      3'd1: begin w_b = 1'b1; w_sgn = 1'b1; end
      3'd2: begin w_h = 1'b1; w_sgn = 1'b1; end
      3'd3: w_w = 1'b1;
      3'd5: w_b = 1'b1;
      3'd6: w_h = 1'b1;
      default: w_bad = 1'b1;
    endcase
  end

  assign w_idx = bus.io_req_addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis = (w_h & bus.io_req_addr[0])
               | (w_w & (|bus.io_req_addr[1:0]));
  assign w_off = bus.io_req_addr[1:0];
`else
  // Misaligned H/W silently drop the low offset bits.
  assign w_mis = 1'b0;
  assign w_off = w_w ? 2'b00
               : w_h ? {bus.io_req_addr[1], 1'b0}
               : bus.io_req_addr[1:0];
`endif

  assign w_rd  = (bus.io_req_func == 2'd0);
  assign w_wr  = (bus.io_req_func == 2'd1);
  assign w_err = (w_rd | w_wr) & (w_bad | w_mis);

  assign w_ready  = (r_state == S_IDLE)
                  | ((r_state == S_RESP) & bus.io_resp_ready);
  assign w_accept = bus.io_req_valid & w_ready;
  assign w_we     = w_accept & w_wr & ~w_err;

  assign w_be = w_w ? 4'hF
              : w_h ? (4'h3 << w_off)
              : w_b ? (4'h1 << w_off)
              : 4'h0;

  assign w_wdat = w_w ? bus.io_req_wdata
                : w_h ? {2{bus.io_req_wdata[15:0]}}
                : {4{bus.io_req_wdata[7:0]}};

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_off, 3'b000};
  assign w_ext   = w_w ? w_shift
                 : w_h ? {{16{w_sgn & w_shift[15]}}, w_shift[15:0]}
                 : {{24{w_sgn & w_shift[7]}}, w_shift[7:0]};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_we && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (w_rd & ~w_err) ? w_ext : 32'd0;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RESP;
      S_RESP: if (bus.io_resp_ready && !w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.io_req_ready  = w_ready;
  assign bus.io_resp_valid = (r_state == S_RESP);
  assign bus.io_resp_rdata = r_rdata;
  assign bus.io_resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomised and directed bench for data_mem_lsu.
// Reference RAM is a plain byte array in little-endian order.
module tb_data_mem_lsu;

  logic clk;
  logic reset_n;

  data_mem_lsu_if #(.ADDR_W(12)) bus();

  data_mem_lsu #(
    .DEPTH  (1024),
    .ADDR_W (12)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic rdy;
  logic [7:0] mm [4096];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(
    input  logic [1:0]  f,
    input  logic [2:0]  t,
    input  logic [11:0] a,
    input  logic [31:0] d,
    output logic [31:0] er,
    output logic        ee
  );
    int sz;
    int base;
    bit sgn;
    logic [31:0] v;
    er = 32'd0;
    ee = 1'b0;
    sz = 0;
    sgn = 1'b0;
    case (t)
      3'd1: begin sz = 1; sgn = 1'b1; end
      3'd2: begin sz = 2; sgn = 1'b1; end
      3'd3: sz = 4;
      3'd5: sz = 1;
      3'd6: sz = 2;
      default: sz = 0;
    endcase
    if (f > 2'd1) return;
    if (sz == 0) begin
      ee = 1'b1;
      return;
    end
    base = int'(a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (base % sz != 0) begin
      ee = 1'b1;
      return;
    end
`endif
    base = base - (base % sz);
    if (f == 2'd1) begin
      for (int i = 0; i < sz; i++) mm[base+i] = d[8*i +: 8];
      return;
    end
    v = 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(mm[base+i]) << (8*i));
    if (sgn && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    er = v;
  endfunction

  task automatic drive(
    input logic [1:0]  f,
    input logic [2:0]  t,
    input logic [11:0] a,
    input logic [31:0] d
  );
    @(negedge clk);
    bus.io_req_valid  = 1'b1;
    bus.io_req_func   = f;
    bus.io_req_typ    = t;
    bus.io_req_addr   = a;
    bus.io_req_wdata  = d;
    bus.io_resp_ready = 1'b1;
    #1;
    rdy = bus.io_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.io_req_valid  = 1'b0;
    bus.io_resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.io_req_valid  = 1'b0;
    bus.io_req_func   = 2'd0;
    bus.io_req_typ    = 3'd3;
    bus.io_req_addr   = '0;
    bus.io_req_wdata  = '0;
    bus.io_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.io_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", bus.io_resp_valid);
    end
    checks++;
    if (bus.io_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", bus.io_req_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.io_req_ready !== 1'b1 || bus.io_resp_rdata !== 32'd0
        || bus.io_resp_err !== 1'b0 || bus.io_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset rdy=%b val=%b rdata=%h err=%b exp 1/0/0/0",
               bus.io_req_ready, bus.io_resp_valid,
               bus.io_resp_rdata, bus.io_resp_err);
    end
  endtask

  task automatic test_fill();
    logic [31:0] er;
    logic ee;
    logic [31:0] d;
    int bad;
    bad = 0;
    for (int w = 0; w < 1024; w++) begin
      d = $urandom;
      drive(2'd1, 3'd3, 12'(w*4), d);
      model(2'd1, 3'd3, 12'(w*4), d, er, ee);
      if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== 32'd0
          || bus.io_resp_err !== 1'b0 || rdy !== 1'b1) bad++;
    end
    idle();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_writes bad_resps=%0d exp=0", bad);
    end
  endtask

  task automatic test_basic();
    drive(2'd1, 3'd3, 12'h010, 32'hDEADBEEF);
    checks++;
    if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL basic_wr val=%b rdata=%h exp 1/0",
               bus.io_resp_valid, bus.io_resp_rdata);
    end
    drive(2'd0, 3'd3, 12'h010, 32'd0);
    checks++;
    if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== 32'hDEADBEEF
        || bus.io_resp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd_w val=%b rdata=%h err=%b exp 1/deadbeef/0",
               bus.io_resp_valid, bus.io_resp_rdata, bus.io_resp_err);
    end
    drive(2'd1, 3'd1, 12'h013, 32'h00000080);
    drive(2'd0, 3'd1, 12'h013, 32'd0);
    checks++;
    if (bus.io_resp_rdata !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL rd_b got=%h exp=ffffff80", bus.io_resp_rdata);
    end
    drive(2'd0, 3'd5, 12'h013, 32'd0);
    checks++;
    if (bus.io_resp_rdata !== 32'h00000080) begin
      errors++;
      $display("FAIL rd_bu got=%h exp=00000080", bus.io_resp_rdata);
    end
    drive(2'd0, 3'd3, 12'h010, 32'd0);
    checks++;
    if (bus.io_resp_rdata !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL rd_w_merged got=%h exp=80adbeef", bus.io_resp_rdata);
    end
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (bus.io_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_return val=%b exp=0", bus.io_resp_valid);
    end
    for (int i = 0; i < 4; i++) mm[16+i] = 8'(32'h80ADBEEF >> (8*i));
  endtask

  task automatic test_misalign();
    drive(2'd0, 3'd2, 12'h011, 32'd0);
    checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (bus.io_resp_err !== 1'b1 || bus.io_resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL mis_rd_h err=%b rdata=%h exp 1/0",
               bus.io_resp_err, bus.io_resp_rdata);
    end
`else
    if (bus.io_resp_err !== 1'b0 || bus.io_resp_rdata !== 32'hFFFFBEEF) begin
      errors++;
      $display("FAIL mis_rd_h err=%b rdata=%h exp 0/ffffbeef",
               bus.io_resp_err, bus.io_resp_rdata);
    end
`endif
    drive(2'd1, 3'd3, 12'h012, 32'h12345678);
    drive(2'd0, 3'd3, 12'h010, 32'd0);
    checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (bus.io_resp_rdata !== 32'h80ADBEEF) begin
      errors++;
      $display("FAIL mis_wr_w got=%h exp=80adbeef", bus.io_resp_rdata);
    end
`else
    if (bus.io_resp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL mis_wr_w got=%h exp=12345678", bus.io_resp_rdata);
    end
    for (int i = 0; i < 4; i++) mm[16+i] = 8'(32'h12345678 >> (8*i));
`endif
    idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] e0;
    logic [31:0] e1;
    logic ee;
    model(2'd0, 3'd3, 12'h010, 32'd0, e0, ee);
    model(2'd0, 3'd3, 12'h014, 32'd0, e1, ee);
    @(negedge clk);
    bus.io_req_valid  = 1'b1;
    bus.io_req_func   = 2'd0;
    bus.io_req_typ    = 3'd3;
    bus.io_req_addr   = 12'h010;
    bus.io_resp_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.io_req_addr = 12'h014;
      #1;
      checks++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== e0
          || bus.io_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d val=%b rdata=%h rdy=%b exp 1/%h/0",
                 k, bus.io_resp_valid, bus.io_resp_rdata,
                 bus.io_req_ready, e0);
      end
    end
    @(negedge clk);
    bus.io_resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.io_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy got=%b exp=1", bus.io_req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== e1) begin
      errors++;
      $display("FAIL bp_next val=%b rdata=%h exp 1/%h",
               bus.io_resp_valid, bus.io_resp_rdata, e1);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] er;
    logic ee;
    drive(2'd1, 3'd3, 12'h020, 32'hCAFEF00D);
    model(2'd1, 3'd3, 12'h020, 32'hCAFEF00D, er, ee);
    @(negedge clk);
    bus.io_req_func   = 2'd0;
    bus.io_resp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.io_req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.io_resp_valid !== 1'b0 || bus.io_resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset val=%b rdata=%h exp 0/0",
               bus.io_resp_valid, bus.io_resp_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'd0, 3'd3, 12'h020, 32'd0);
    checks++;
    if (bus.io_resp_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL mid_reset_keep got=%h exp=cafef00d", bus.io_resp_rdata);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    logic ee;
    logic [31:0] d;
    logic [11:0] a;
    for (int k = 0; k < 16; k++) begin
      a = 12'h100 + 12'(k*4);
      d = $urandom;
      drive(2'd1, 3'd3, a, d);
      model(2'd1, 3'd3, a, d, er, ee);
      drive(2'd0, 3'd3, a, 32'd0);
      model(2'd0, 3'd3, a, 32'd0, er, ee);
      checks++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== er
          || rdy !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d val=%b rdata=%h rdy=%b exp 1/%h/1",
                 k, bus.io_resp_valid, bus.io_resp_rdata, rdy, er);
      end
    end
    drive(2'd0, 3'd7, 12'h100, 32'd0);
    checks++;
    if (bus.io_resp_err !== 1'b1 || bus.io_resp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL typ7 err=%b rdata=%h exp 1/0",
               bus.io_resp_err, bus.io_resp_rdata);
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] er;
    logic ee;
    logic [1:0]  f;
    logic [2:0]  t;
    logic [11:0] a;
    logic [31:0] d;
    int sel;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      f = (sel < 5) ? 2'd0 : (sel < 9) ? 2'd1 : 2'(2 + $urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      t = (sel == 0) ? 3'd1 : (sel == 1) ? 3'd2 : (sel == 2) ? 3'd3
        : (sel == 3) ? 3'd5 : (sel == 4) ? 3'd6 : 3'($urandom_range(0, 7));
      if (f > 2'd1) t = 3'd1;
      a = 12'($urandom);
      d = $urandom;
      drive(f, t, a, d);
      model(f, t, a, d, er, ee);
      checks++;
      if (bus.io_resp_valid !== 1'b1 || bus.io_resp_rdata !== er
          || bus.io_resp_err !== ee) begin
        errors++;
        $display("FAIL rand%0d f=%0d t=%0d a=%h val=%b rdata=%h err=%b exp %h/%b",
                 n, f, t, a, bus.io_resp_valid, bus.io_resp_rdata,
                 bus.io_resp_err, er, ee);
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_misalign();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
